// File: rtl/e203_exu_wbck_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_wbck_buf_if
// Description : Write-back bundle between the ALU / long-pipe result
//               producers, the write-back buffer and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface e203_exu_wbck_buf_if;
  logic        alu_wbck_i_valid;
  logic        alu_wbck_i_ready;
  logic [31:0] alu_wbck_i_wdat;
  logic [4:0]  alu_wbck_i_rdidx;
  logic        longp_wbck_i_valid;
  logic        longp_wbck_i_ready;
  logic [31:0] longp_wbck_i_wdat;
  logic [4:0]  longp_wbck_i_rdidx;
  logic        rf_wbck_o_ena;
  logic [4:0]  rf_wbck_o_rdidx;
  logic [31:0] rf_wbck_o_wdat;
  logic [1:0]  longp_fifo_cnt;

  // Producer / regfile side
  modport master (
    output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
    input  alu_wbck_i_ready, longp_wbck_i_ready,
    input  rf_wbck_o_ena, rf_wbck_o_rdidx, rf_wbck_o_wdat, longp_fifo_cnt
  );

  // Write-back buffer side
  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
    output alu_wbck_i_ready, longp_wbck_i_ready,
    output rf_wbck_o_ena, rf_wbck_o_rdidx, rf_wbck_o_wdat, longp_fifo_cnt
  );
endinterface
`default_nettype wire

// File: rtl/e203_exu_wbck_buf.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_wbck_buf
// Description : Write-back arbiter. Long-pipe results are queued in a 2-entry
//               in-order FIFO and have fixed priority over ALU results; the
//               selected write is registered toward the register file. Writes
//               to x0 complete their handshake but never assert the enable.
//               Optional macro E203_WBCK_PERF_CNT_EN adds a wbck_cnt output
//               counting cycles with the regfile write enable asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_wbck_buf (
  input  wire                          clk,
  input  wire                          rst_n,
`ifdef E203_WBCK_PERF_CNT_EN
  output logic [31:0]                  wbck_cnt,
`endif
  e203_exu_wbck_buf_if.slave           bus
);

  localparam logic [1:0] c_fifo_full = 2'd2;

  logic [31:0] r_fifo_dat [0:1];
  logic [4:0]  r_fifo_idx [0:1];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_cnt;

  logic        r_rf_ena;
  logic [4:0]  r_rf_idx;
  logic [31:0] r_rf_dat;

  logic        w_longp_ready;
  logic        w_fifo_nempty;
  logic        w_push;
  logic        w_pop;
  logic        w_alu_ready;
  logic        w_alu_hsk;
  logic        w_sel;
  logic [4:0]  w_sel_idx;
  logic [31:0] w_sel_dat;
  logic        w_wr;

  // Readiness comes from registered occupancy only, so no valid->ready path.
  assign w_longp_ready = (r_cnt != c_fifo_full);
  assign w_fifo_nempty = (r_cnt != 2'd0);
  assign w_push        = bus.longp_wbck_i_valid & w_longp_ready;
  assign w_pop         = w_fifo_nempty;
  assign w_alu_ready   = ~w_fifo_nempty;
  assign w_alu_hsk     = bus.alu_wbck_i_valid & w_alu_ready;
  assign w_sel         = w_pop | w_alu_hsk;
  assign w_sel_idx     = w_pop ? r_fifo_idx[r_rptr] : bus.alu_wbck_i_rdidx;
  assign w_sel_dat     = w_pop ? r_fifo_dat[r_rptr] : bus.alu_wbck_i_wdat;
  // x0 writes retire but leave the regfile interface untouched.
  assign w_wr          = w_sel & (w_sel_idx != 5'd0);

  // FIFO storage: contents need no reset, pointers/count gate their use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dat[r_wptr] <= bus.longp_wbck_i_wdat;
      r_fifo_idx[r_wptr] <= bus.longp_wbck_i_rdidx;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as 1-bit values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Registered regfile write; index/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_ena <= 1'b0;
      r_rf_idx <= 5'd0;
      r_rf_dat <= 32'd0;
    end else begin
      r_rf_ena <= w_wr;
      if (w_wr) begin
        r_rf_idx <= w_sel_idx;
        r_rf_dat <= w_sel_dat;
      end
    end
  end

`ifdef E203_WBCK_PERF_CNT_EN
  logic [31:0] r_wbck_cnt;

  // Count cycles with the regfile write enable high; wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbck_cnt <= 32'd0;
    end else if (r_rf_ena) begin
      r_wbck_cnt <= r_wbck_cnt + 32'd1;
    end
  end

  assign wbck_cnt = r_wbck_cnt;
`endif

  assign bus.alu_wbck_i_ready   = w_alu_ready;
  assign bus.longp_wbck_i_ready = w_longp_ready;
  assign bus.rf_wbck_o_ena      = r_rf_ena;
  assign bus.rf_wbck_o_rdidx    = r_rf_idx;
  assign bus.rf_wbck_o_wdat     = r_rf_dat;
  assign bus.longp_fifo_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_wbck_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_e203_exu_wbck_buf
// Description : Directed + short random bench for e203_exu_wbck_buf with a
//               reference FIFO model and expected-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e203_exu_wbck_buf;

  logic clk;
  logic rst_n;
`ifdef E203_WBCK_PERF_CNT_EN
  logic [31:0] wbck_cnt;
`endif

  e203_exu_wbck_buf_if bus ();

  e203_exu_wbck_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef E203_WBCK_PERF_CNT_EN
    .wbck_cnt (wbck_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [36:0] lq   [$];   // long-pipe FIFO model {idx,dat}
  logic [36:0] wr_q [$];   // expected regfile writes {idx,dat}
  logic        m_ena;
  logic [4:0]  m_idx;
  logic [31:0] m_dat;
  logic [31:0] m_wcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [36:0] e;
    chk("rf_ena", {31'd0, bus.rf_wbck_o_ena}, {31'd0, m_ena});
    if (m_ena) begin
      e = wr_q.pop_front();
      m_idx = e[36:32];
      m_dat = e[31:0];
    end
    chk("rf_rdidx", {27'd0, bus.rf_wbck_o_rdidx}, {27'd0, m_idx});
    chk("rf_wdat", bus.rf_wbck_o_wdat, m_dat);
    chk("fifo_cnt", {30'd0, bus.longp_fifo_cnt}, lq.size());
`ifdef E203_WBCK_PERF_CNT_EN
    chk("wbck_cnt", wbck_cnt, m_wcnt);
`endif
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld);
    logic [36:0] sel;
    logic        sel_v;
    int          old_sz;
    bus.alu_wbck_i_valid   = av;
    bus.alu_wbck_i_rdidx   = ai;
    bus.alu_wbck_i_wdat    = ad;
    bus.longp_wbck_i_valid = lv;
    bus.longp_wbck_i_rdidx = li;
    bus.longp_wbck_i_wdat  = ld;
    @(negedge clk);
    old_sz = lq.size();
    chk("alu_ready", {31'd0, bus.alu_wbck_i_ready}, (old_sz == 0) ? 32'd1 : 32'd0);
    chk("longp_ready", {31'd0, bus.longp_wbck_i_ready}, (old_sz != 2) ? 32'd1 : 32'd0);
    sel_v = 1'b0;
    sel   = '0;
    if (old_sz != 0) begin
      sel   = lq.pop_front();
      sel_v = 1'b1;
    end else if (av) begin
      sel   = {ai, ad};
      sel_v = 1'b1;
    end
    if (lv && old_sz != 2) lq.push_back({li, ld});
    @(posedge clk);
    m_wcnt = m_wcnt + {31'd0, m_ena};
    m_ena  = sel_v && (sel[36:32] != 5'd0);
    if (m_ena) wr_q.push_back(sel);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drive_zero();
    bus.alu_wbck_i_valid   = 1'b0;
    bus.alu_wbck_i_rdidx   = 5'd0;
    bus.alu_wbck_i_wdat    = 32'd0;
    bus.longp_wbck_i_valid = 1'b0;
    bus.longp_wbck_i_rdidx = 5'd0;
    bus.longp_wbck_i_wdat  = 32'd0;
  endtask

  task automatic check_reset_state();
    chk("rst_ena", {31'd0, bus.rf_wbck_o_ena}, 32'd0);
    chk("rst_rdidx", {27'd0, bus.rf_wbck_o_rdidx}, 32'd0);
    chk("rst_wdat", bus.rf_wbck_o_wdat, 32'd0);
    chk("rst_cnt", {30'd0, bus.longp_fifo_cnt}, 32'd0);
    chk("rst_alu_ready", {31'd0, bus.alu_wbck_i_ready}, 32'd1);
    chk("rst_longp_ready", {31'd0, bus.longp_wbck_i_ready}, 32'd1);
`ifdef E203_WBCK_PERF_CNT_EN
    chk("rst_wbck_cnt", wbck_cnt, 32'd0);
`endif
  endtask

  // Asynchronous reset asserted mid-cycle, away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    drive_zero();
    rst_n = 1'b0;
    #1;
    lq.delete();
    wr_q.delete();
    m_ena  = 1'b0;
    m_idx  = 5'd0;
    m_dat  = 32'd0;
    m_wcnt = 32'd0;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_zero();
    rst_n  = 1'b0;
    m_ena  = 1'b0;
    m_idx  = 5'd0;
    m_dat  = 32'd0;
    m_wcnt = 32'd0;
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU write with empty FIFO: one-cycle latency
    cycle(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    idle();

    // Back-to-back long-pipe pushes with ALU valid throughout
    cycle(1'b1, 5'd9,  32'hC0, 1'b1, 5'd3, 32'hA);
    cycle(1'b1, 5'd10, 32'hC1, 1'b1, 5'd4, 32'hB);
    cycle(1'b1, 5'd11, 32'hC2, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd12, 32'hC3, 1'b0, 5'd0, 32'd0);
    idle();
    idle();

    // x0 write: handshake completes, outputs hold
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    idle();

    // Count 1 with simultaneous push and pop
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    idle();
    idle();

    // Long-pipe x0 entry is popped but never written
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    cycle(1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd14, 32'hD1, 1'b0, 5'd0, 32'd0);
    idle();

    // Short random traffic
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    idle();
    idle();

    // Reset with an entry in flight: nothing stale may come out
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    do_reset();
    idle();
    idle();
    idle();

`ifdef E203_WBCK_PERF_CNT_EN
    // Three real writes plus one x0 write
    cycle(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd0, 32'h4, 1'b0, 5'd0, 32'd0);
    idle();
    chk("wbck_cnt_three", wbck_cnt, 32'd3);
    // Wrap from all-ones
    force dut.r_wbck_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_wbck_cnt;
    m_wcnt = 32'hFFFF_FFFF;
    cycle(1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 32'd0);
    idle();
    chk("wbck_cnt_wrap", wbck_cnt, 32'd0);
`endif

    chk("scoreboard_drained", wr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
